// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0]   BIT_LAST = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;
`endif

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          overflow_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif
    logic          full;
    logic          push;
    logic          pop;
    logic          bit_end;

    always_comb begin
        full    = (count_q == FULL);
        pop     = (state_q == StIdle) && (count_q != '0);
        // A full FIFO drops the byte even if a pop frees a slot this cycle.
        push    = in_valid && !full;
        bit_end = (cnt_q == BIT_LAST);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (in_valid && full) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // Includes the current state so busy stays high through the last stop cycle.
            busy_q <= (state_q != StIdle) || pop || (count_d != '0);
            cnt_q  <= bit_end ? '0 : cnt_q + 1'b1;
            case (state_q)
                StIdle: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        tx_q     <= 1'b0;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLK_DIV=4, FIFO_DEPTH=4.
// Build with UART_TX_PARITY_EN defined to exercise the 8E1 frame.
module tb_uart_tx_fifo;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int LAST = 45;
`else
    localparam int LAST = 41;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tx for a lone frame pushed at cycle 0 from an idle, empty DUT.
    function automatic logic exp_tx(input int c, input logic [7:0] b);
        logic [7:0] v;
        if (c < 2) return 1'b1;
        if (c < 6) return 1'b0;
        if (c < 38) begin
            v = b >> ((c - 6) / 4);
            return v[0];
        end
`ifdef UART_TX_PARITY_EN
        if (c < 42) return ^b;
`endif
        return 1'b1;
    endfunction

    // Waits (bounded) for a start bit, then samples each bit near its middle.
    task automatic recv_check(input string tag, input logic [7:0] exp);
        int         waited;
        logic [7:0] b;
        waited = 0;
        b      = '0;
        while (tx !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        if (tx !== 1'b0) begin
            check($sformatf("%s_timeout", tag), 32'(tx), 32'd0);
            return;
        end
        tick();
        check($sformatf("%s_start", tag), 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) tick();
            b[i] = tx;
        end
        check($sformatf("%s_data", tag), 32'(b), 32'(exp));
`ifdef UART_TX_PARITY_EN
        repeat (CLK_DIV) tick();
        check($sformatf("%s_parity", tag), 32'(tx), 32'(^exp));
`endif
        repeat (CLK_DIV) tick();
        check($sformatf("%s_stop", tag), 32'(tx), 32'd1);
    endtask

    initial begin
        int lows;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single 0x55 frame, cycle-exact.
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 1; c <= LAST + 2; c++) begin
            tick();
            in_valid = 1'b0;
            check($sformatf("f55_tx_c%0d", c), 32'(tx), 32'(exp_tx(c, 8'h55)));
            check($sformatf("f55_busy_c%0d", c), 32'(busy), 32'(c <= LAST + 1));
            if (c == 1) check("f55_count_c1", 32'(fifo_count), 32'd1);
            if (c == 2) check("f55_count_c2", 32'(fifo_count), 32'd0);
        end

        // Three back-to-back bytes come out in order.
        in_valid = 1'b1;
        in_data  = 8'hA1;
        tick();
        check("abc_count_c1", 32'(fifo_count), 32'd1);
        in_data = 8'hB2;
        tick();
        check("abc_count_c2", 32'(fifo_count), 32'd1);
        in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        check("abc_count_peak", 32'(fifo_count), 32'd2);
        recv_check("abc_a1", 8'hA1);
        recv_check("abc_b2", 8'hB2);
        recv_check("abc_c3", 8'hC3);
        repeat (4) tick();
        check("abc_busy_end", 32'(busy), 32'd0);

        // Fill while a frame is in flight: fifth byte dropped, overflow sticky.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 14) begin
                check("ovf_count_c14", 32'(fifo_count), 32'd4);
                check("ovf_flag_c14", 32'(overflow), 32'd0);
            end
            if (c == 15) begin
                check("ovf_count_c15", 32'(fifo_count), 32'd4);
                check("ovf_flag_c15", 32'(overflow), 32'd1);
            end
            in_valid = (c >= 10 && c <= 14);
            in_data  = 8'(c - 9);
        end
        for (int i = 1; i <= 4; i++) recv_check($sformatf("ovf_b%0d", i), 8'(i));
        repeat (4) tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_busy_end", 32'(busy), 32'd0);
        check("ovf_count_end", 32'(fifo_count), 32'd0);

        // Reset during data bit 3 with two bytes queued; in_valid under reset ignored.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int c = 1; c <= 20; c++) begin
            tick();
            in_valid = (c == 3 || c == 4);
            in_data  = (c == 3) ? 8'h11 : 8'h22;
            if (c == 19) begin
                check("mrst_count_pre", 32'(fifo_count), 32'd2);
                rst      = 1'b1;
                in_valid = 1'b1;
                in_data  = 8'h77;
            end
            if (c == 20) begin
                rst      = 1'b0;
                in_valid = 1'b0;
                check("mrst_tx", 32'(tx), 32'd1);
                check("mrst_count", 32'(fifo_count), 32'd0);
                check("mrst_busy", 32'(busy), 32'd0);
                check("mrst_ovf", 32'(overflow), 32'd0);
            end
        end
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("mrst_no_frames", 32'(lows), 32'd0);
        check("mrst_busy_after", 32'(busy), 32'd0);

        // Push coincides with the IDLE pop at count 3: count holds, order kept.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 1; c <= LAST + 2; c++) begin
            tick();
            in_valid = (c >= 10 && c <= 12) || (c == LAST + 1);
            in_data  = (c == LAST + 1) ? 8'h34 : 8'(8'h31 + c - 10);
            if (c == LAST + 1) check("pp_count_pre", 32'(fifo_count), 32'd3);
            if (c == LAST + 2) begin
                check("pp_count_post", 32'(fifo_count), 32'd3);
                check("pp_ovf", 32'(overflow), 32'd0);
            end
        end
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) recv_check($sformatf("pp_b%0d", i), 8'(8'h30 + i));

`ifdef UART_TX_PARITY_EN
        repeat (4) tick();
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        in_valid = 1'b0;
        recv_check("par_03", 8'h03);
`endif

        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per serial bit period (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  one-cycle byte strobe; driven by the MMIO cpu_uart_data_valid output.
REQ-006 in_data  input  8  byte to transmit, sampled when in_valid=1; driven by the MMIO cpu_uart_data output.
REQ-007 tx  output  1  serial line, idle high, 8N1 frame (8E1 with the macro in REQ-025).
REQ-008 busy  output  1  high when the FIFO is non-empty or a frame is in progress.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-011 FIFO push: in_valid=1 with fifo_count<FIFO_DEPTH at edge N writes in_data; fifo_count increments at edge N.
REQ-012 Full-FIFO drop: in_valid=1 with fifo_count==FIFO_DEPTH drops the byte and sets overflow at the same edge, even when a pop occurs in that cycle; FIFO contents unchanged.
REQ-013 Simultaneous push and pop with FIFO not full: fifo_count unchanged, FIFO order preserved.
REQ-014 Read/write pointers wrap modulo FIFO_DEPTH; bytes leave in arrival order.
REQ-015 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: tx=1; when fifo_count!=0, pop the head byte into the shift register and enter START at that edge.
REQ-017 START: tx=0 for exactly CLK_DIV cycles, then DATA.
REQ-018 DATA: 8 bits, LSB first, CLK_DIV cycles each; after bit 7, go to PARITY if enabled, else STOP.
REQ-019 STOP: tx=1 for CLK_DIV cycles, then IDLE; the minimum gap between frames is therefore one IDLE cycle.
REQ-020 The bit-period counter clears on every state transition; bit timing is exact, with no cumulative drift.
REQ-021 Latency: with an empty FIFO and IDLE state, in_valid at cycle 0 causes tx to fall at cycle 2 (push at edge 0, pop/START at edge 1).
REQ-022 busy = (state!=IDLE) or (fifo_count!=0), registered-equivalent; it goes high at cycle 1 of REQ-021 and low one cycle after the last STOP bit completes.
REQ-023 tx is driven from a register; no combinational path from in_valid to tx.

Reset
REQ-024 On rst=1 at any edge, including mid-frame: state=IDLE, tx=1, FIFO emptied, fifo_count=0, overflow=0, busy=0, counters cleared, all effective at the next cycle; in_valid during rst is ignored.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, the PARITY state transmits the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles between DATA and STOP, giving an 11-bit frame; when undefined, the PARITY state and its logic do not exist and the frame is 10 bits.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-026 Reset, then in_valid=1, in_data=0x55 at cycle 0 -> tx=0 for cycles 2-5, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for cycles 38-41, busy low at cycle 43.
REQ-027 Push 0xA1, 0xB2, 0xC3 on consecutive cycles -> three frames in order, decoded 0xA1, 0xB2, 0xC3, fifo_count peaks at 2 (first byte already popped).
REQ-028 Hold the FSM mid-frame, push 5 bytes 0x01..0x05 back-to-back -> 0x01..0x04 accepted, 0x05 dropped, overflow=1 and remains set after all frames drain.
REQ-029 Assert rst during DATA bit 3 with 2 bytes queued -> next cycle tx=1, fifo_count=0, busy=0, overflow=0; no further frames are sent.
REQ-030 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 follows the data bits; send 0x03 -> parity bit 0; frame length 44 cycles.
REQ-031 Simultaneous pop and push at fifo_count=3 -> count stays 3, no overflow, byte order preserved.
